// File: rtl/nf1g_rbs_arbiter.sv
// Register-bus ring origin: round-robin arbiter for up to four local requesters with one
// outstanding transaction, SRC tagging, return matching, timeout and stray accounting.
module nf1g_rbs_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_rd_wr_L,
  input  logic [NUM_REQ*30-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,

  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_data,
  output logic                    resp_err,

  output logic                    M_RBS_REQ,
  output logic                    M_RBS_ACK,
  output logic                    M_RBS_RD_WR_L,
  output logic [29:0]             M_RBS_ADDR,
  output logic [31:0]             M_RBS_DATA,
  output logic [1:0]              M_RBS_SRC,

  input  logic                    S_RBS_REQ,
  input  logic                    S_RBS_ACK,
  input  logic                    S_RBS_RD_WR_L,
  input  logic [29:0]             S_RBS_ADDR,
  input  logic [31:0]             S_RBS_DATA,
  input  logic [1:0]              S_RBS_SRC,

  output logic [7:0]              stray_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0]  LastGrantInit = 2'(NUM_REQ - 1);
  localparam logic [15:0] TimerLast     = 16'(TIMEOUT - 1);
  localparam logic [31:0] TimeoutData   = 32'hDEAD_BEEF;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_grant;
  logic [1:0]  r_last_grant;
  logic        r_rd_wr_L;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_timer;
  logic [31:0] r_resp_data;
  logic        r_resp_err;
  logic [7:0]  r_stray_cnt;

  logic [3:0]  w_valid_pad;
  logic [1:0]  w_pick;
  logic        w_any;
  logic        w_accept;
  logic        w_sel_rd_wr_L;
  logic [29:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_match;
  logic        w_timeout;
  logic        w_stray;
  logic        w_unused_ring;

  // Return address and direction are not needed to match; SRC alone identifies the owner.
  assign w_unused_ring = ^{S_RBS_ADDR, S_RBS_RD_WR_L};

  // Round-robin scan starting one past the last completed grant.
  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_REQ-1:0]   = req_valid;
    w_any                      = 1'b0;
    w_pick                     = r_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && w_valid_pad[2'((32'(r_last_grant) + k) % NUM_REQ)]) begin
        w_any  = 1'b1;
        w_pick = 2'((32'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_sel_rd_wr_L = 1'b0;
    w_sel_addr    = '0;
    w_sel_wdata   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(w_pick) == i) begin
        w_sel_rd_wr_L = req_rd_wr_L[i];
        w_sel_addr    = req_addr[30*i +: 30];
        w_sel_wdata   = req_wdata[32*i +: 32];
      end
    end
  end

  assign w_accept  = (r_state == StIdle) && w_any;
  assign w_match   = (r_state == StWait) && S_RBS_REQ && (S_RBS_SRC == r_grant);
  assign w_timeout = (r_state == StWait) && (r_timer == TimerLast);
  assign w_stray   = S_RBS_REQ && !w_match;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StIssue;
      StIssue: w_state_nxt = StWait;
      StWait:  if (w_match || w_timeout) w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_grant      <= '0;
      r_last_grant <= LastGrantInit;
      r_rd_wr_L    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_timer      <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_stray_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant   <= w_pick;
        r_rd_wr_L <= w_sel_rd_wr_L;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
      end
      if (r_state == StIssue) begin
        r_timer <= '0;
      end else if (r_state == StWait) begin
        r_timer <= r_timer + 16'd1;
      end
      // A true return beats a coincident timeout.
      if (w_match) begin
        r_resp_data <= S_RBS_DATA;
        r_resp_err  <= ~S_RBS_ACK;
      end else if (w_timeout) begin
        r_resp_data <= TimeoutData;
        r_resp_err  <= 1'b1;
      end
      if (r_state == StResp) begin
        r_last_grant <= r_grant;
      end
      if (w_stray && (r_stray_cnt != 8'hFF)) begin
        r_stray_cnt <= r_stray_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = w_accept && (32'(w_pick) == i);
      resp_valid[i] = (r_state == StResp) && (32'(r_grant) == i);
    end
  end

  assign resp_data     = (r_state == StResp)  ? r_resp_data : '0;
  assign resp_err      = (r_state == StResp)  ? r_resp_err  : 1'b0;

  assign M_RBS_REQ     = (r_state == StIssue);
  assign M_RBS_ACK     = 1'b0;
  assign M_RBS_RD_WR_L = (r_state == StIssue) ? r_rd_wr_L : 1'b0;
  assign M_RBS_ADDR    = (r_state == StIssue) ? r_addr    : '0;
  assign M_RBS_DATA    = (r_state == StIssue) ? r_wdata   : '0;
  assign M_RBS_SRC     = (r_state == StIssue) ? r_grant   : '0;

  assign stray_cnt     = r_stray_cnt;

endmodule

// File: tb/tb_nf1g_rbs_arbiter.sv
// Scoreboard bench for nf1g_rbs_arbiter: stimulus pushes expected ring issues and responses,
// a negedge monitor pops and compares them; a ring model loops back or injects returns.
module tb_nf1g_rbs_arbiter;

  localparam int NREQ = 2;
  localparam int TO   = 16;

  typedef struct {
    logic [1:0]  src;
    logic        rd;
    logic [29:0] addr;
    logic [31:0] data;
  } issue_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    int          lat;
  } resp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_rd_wr_L = '0;
  logic [NREQ*30-1:0]   req_addr = '0;
  logic [NREQ*32-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_data;
  logic                 resp_err;
  logic                 M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L;
  logic [29:0]          M_RBS_ADDR;
  logic [31:0]          M_RBS_DATA;
  logic [1:0]           M_RBS_SRC;
  logic                 S_RBS_REQ = 1'b0, S_RBS_ACK = 1'b0, S_RBS_RD_WR_L = 1'b0;
  logic [29:0]          S_RBS_ADDR = '0;
  logic [31:0]          S_RBS_DATA = '0;
  logic [1:0]           S_RBS_SRC = '0;
  logic [7:0]           stray_cnt;

  always #5 clk = ~clk;

  nf1g_rbs_arbiter #(
    .NUM_REQ (NREQ),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd_wr_L   (req_rd_wr_L),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .M_RBS_REQ     (M_RBS_REQ),
    .M_RBS_ACK     (M_RBS_ACK),
    .M_RBS_RD_WR_L (M_RBS_RD_WR_L),
    .M_RBS_ADDR    (M_RBS_ADDR),
    .M_RBS_DATA    (M_RBS_DATA),
    .M_RBS_SRC     (M_RBS_SRC),
    .S_RBS_REQ     (S_RBS_REQ),
    .S_RBS_ACK     (S_RBS_ACK),
    .S_RBS_RD_WR_L (S_RBS_RD_WR_L),
    .S_RBS_ADDR    (S_RBS_ADDR),
    .S_RBS_DATA    (S_RBS_DATA),
    .S_RBS_SRC     (S_RBS_SRC),
    .stray_cnt     (stray_cnt)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_acc = 0;
  int     issue_cyc = 0;
  issue_t exp_issue[$];
  resp_t  exp_resp[$];
  issue_t ie;
  resp_t  re;

  // Ring model controls, written only by the stimulus process.
  logic        loop_en = 1'b0, loop_ack = 1'b1, loop_ovr = 1'b0;
  logic [31:0] loop_data = '0;
  logic        inj_en = 1'b0, inj_ack = 1'b0;
  logic [1:0]  inj_src = '0;
  logic [31:0] inj_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ring: a loopback replies in the cycle after the issue; injections are driven otherwise.
  initial begin
    logic        pend;
    logic [1:0]  p_src;
    logic [31:0] p_data;
    forever begin
      @(negedge clk);
      pend = loop_en && M_RBS_REQ;
      p_src = M_RBS_SRC;
      p_data = loop_ovr ? loop_data : M_RBS_DATA;
      @(posedge clk);
      #2;
      if (pend) begin
        S_RBS_REQ = 1'b1; S_RBS_ACK = loop_ack; S_RBS_SRC = p_src; S_RBS_DATA = p_data;
      end else if (inj_en) begin
        S_RBS_REQ = 1'b1; S_RBS_ACK = inj_ack; S_RBS_SRC = inj_src; S_RBS_DATA = inj_data;
      end else begin
        S_RBS_REQ = 1'b0; S_RBS_ACK = 1'b0; S_RBS_SRC = '0; S_RBS_DATA = '0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (|req_ready) last_acc = cyc;
    if (M_RBS_REQ) begin
      if (exp_issue.size() == 0) begin
        chk("issue_unexpected", 64'(M_RBS_SRC), 64'hFF);
      end else begin
        ie = exp_issue.pop_front();
        chk("issue_src", 64'(M_RBS_SRC), 64'(ie.src));
        chk("issue_rd", 64'(M_RBS_RD_WR_L), 64'(ie.rd));
        chk("issue_addr", 64'(M_RBS_ADDR), 64'(ie.addr));
        chk("issue_data", 64'(M_RBS_DATA), 64'(ie.data));
        chk("issue_ack", 64'(M_RBS_ACK), 64'd0);
        chk("issue_latency", 64'(cyc - last_acc), 64'd1);
        issue_cyc = cyc;
      end
    end else begin
      chk("ring_idle_zero", 64'({M_RBS_ACK, M_RBS_RD_WR_L, M_RBS_SRC, M_RBS_ADDR}), 64'd0);
      chk("ring_idle_data", 64'(M_RBS_DATA), 64'd0);
    end
    if (|resp_valid) begin
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        re = exp_resp.pop_front();
        chk("resp_onehot", 64'(resp_valid), 64'd1 << re.idx);
        chk("resp_data", 64'(resp_data), 64'(re.data));
        chk("resp_err", 64'(resp_err), 64'(re.err));
        chk("resp_latency", 64'(cyc - issue_cyc), 64'(re.lat));
      end
    end else begin
      chk("resp_idle_zero", 64'({resp_err, resp_data}), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic [1:0] src, input logic rd, input logic [29:0] a,
                          input logic [31:0] d);
    issue_t t;
    t.src = src; t.rd = rd; t.addr = a; t.data = d;
    exp_issue.push_back(t);
  endtask

  task automatic push_rsp(input int idx, input logic [31:0] d, input logic e, input int lat);
    resp_t t;
    t.idx = idx; t.data = d; t.err = e; t.lat = lat;
    exp_resp.push_back(t);
  endtask

  task automatic set_fields(input int idx, input logic rd, input logic [29:0] a,
                            input logic [31:0] d);
    req_rd_wr_L[idx]      = rd;
    req_addr[30*idx +: 30] = a;
    req_wdata[32*idx +: 32] = d;
  endtask

  // Raise one request and hold it until accepted; returns at the ISSUE cycle (+1).
  task automatic do_req(input int idx, input logic rd, input logic [29:0] a,
                        input logic [31:0] d);
    logic got;
    set_fields(idx, rd, a, d);
    req_valid[idx] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
    end
    chk("req_accepted", 64'(got), 64'd1);
    step();
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && exp_resp.size() > 0; n++) @(negedge clk);
    chk("resp_drained", 64'(exp_resp.size()), 64'd0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({req_ready, resp_valid, resp_err, M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L,
                   M_RBS_SRC, stray_cnt}), 64'd0);
    chk({name, "_buses"}, 64'({resp_data, M_RBS_DATA}) | 64'(M_RBS_ADDR), 64'd0);
  endtask

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    chk_all_zero("reset_outputs");

    // Single read, loopback with forced data.
    loop_en = 1'b1; loop_ack = 1'b1; loop_ovr = 1'b1; loop_data = 32'h1234_5678;
    step();
    push_iss(2'd0, 1'b1, 30'h3b00003, 32'h0);
    push_rsp(0, 32'h1234_5678, 1'b0, 2);
    do_req(0, 1'b1, 30'h3b00003, 32'h0);
    drain(20);

    // Round-robin with both requesters held valid, write data echoed.
    do_reset();
    loop_ovr = 1'b0;
    set_fields(0, 1'b0, 30'h0000100, 32'hAAAA_0000);
    set_fields(1, 1'b1, 30'h0000204, 32'h5555_1111);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        push_iss(2'd0, 1'b0, 30'h0000100, 32'hAAAA_0000);
        push_rsp(0, 32'hAAAA_0000, 1'b0, 2);
      end else begin
        push_iss(2'd1, 1'b1, 30'h0000204, 32'h5555_1111);
        push_rsp(1, 32'h5555_1111, 1'b0, 2);
      end
    end
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      if (|req_ready) n++;
    end
    step();
    req_valid = 2'b00;
    chk("rr_accepts", 64'(n), 64'd6);
    drain(40);

    // Unclaimed: ack=0 loopback echoes the write data with err set.
    loop_ack = 1'b0;
    push_iss(2'd1, 1'b0, 30'h1234567, 32'hA5A5_0F0F);
    push_rsp(1, 32'hA5A5_0F0F, 1'b1, 2);
    do_req(1, 1'b0, 30'h1234567, 32'hA5A5_0F0F);
    drain(20);

    // Timeout: ring never returns.
    loop_en = 1'b0; loop_ack = 1'b1;
    push_iss(2'd0, 1'b0, 30'h0000040, 32'h0BAD_F00D);
    push_rsp(0, 32'hDEAD_BEEF, 1'b1, TO + 1);
    do_req(0, 1'b0, 30'h0000040, 32'h0BAD_F00D);
    drain(60);

    // Matching return in the timeout cycle wins.
    push_iss(2'd0, 1'b1, 30'h0000044, 32'h0);
    push_rsp(0, 32'h600D_CAFE, 1'b0, TO + 1);
    do_req(0, 1'b1, 30'h0000044, 32'h0);
    repeat (TO) step();
    inj_en = 1'b1; inj_src = 2'd0; inj_ack = 1'b1; inj_data = 32'h600D_CAFE;
    step();
    inj_en = 1'b0;
    drain(20);

    // Strays: one in IDLE, one with wrong SRC in WAIT, then the true return.
    do_reset();
    inj_en = 1'b1; inj_src = 2'd0; inj_ack = 1'b1; inj_data = 32'h1111_1111;
    step();
    inj_en = 1'b0;
    step();
    push_iss(2'd0, 1'b0, 30'h0000080, 32'h7777_7777);
    push_rsp(0, 32'hC0FF_EE11, 1'b0, 3);
    do_req(0, 1'b0, 30'h0000080, 32'h7777_7777);
    step();
    inj_en = 1'b1; inj_src = 2'd1; inj_ack = 1'b1; inj_data = 32'h0000_0BAD;
    step();
    inj_src = 2'd0; inj_data = 32'hC0FF_EE11;
    step();
    inj_en = 1'b0;
    drain(20);
    @(negedge clk);
    chk("stray_cnt_two", 64'(stray_cnt), 64'd2);

    // Reset mid-WAIT; previous completed grant was requester 0.
    step();
    push_iss(2'd0, 1'b1, 30'h00000C0, 32'h0);
    do_req(0, 1'b1, 30'h00000C0, 32'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid_wait");
    step();
    inj_en = 1'b1; inj_src = 2'd0; inj_ack = 1'b1; inj_data = 32'h0DD0_0DD0;
    step();
    inj_en = 1'b0;
    @(negedge clk);
    chk("stray_after_reset", 64'(stray_cnt), 64'd1);
    step();
    loop_en = 1'b1; loop_ack = 1'b1; loop_ovr = 1'b0;
    set_fields(0, 1'b0, 30'h0000300, 32'h0000_0A0A);
    set_fields(1, 1'b0, 30'h0000304, 32'h0000_0B0B);
    push_iss(2'd0, 1'b0, 30'h0000300, 32'h0000_0A0A);
    push_rsp(0, 32'h0000_0A0A, 1'b0, 2);
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 50 && n == 0; c++) begin
      @(negedge clk);
      if (|req_ready) n++;
    end
    step();
    req_valid = 2'b00;
    chk("post_reset_accept", 64'(n), 64'd1);
    drain(20);

    // Stray counter saturation.
    loop_en = 1'b0;
    do_reset();
    inj_en = 1'b1; inj_src = 2'd3; inj_ack = 1'b0; inj_data = 32'h0;
    repeat (254) step();
    @(negedge clk);
    chk("stray_cnt_254", 64'(stray_cnt), 64'd254);
    step();
    @(negedge clk);
    chk("stray_cnt_255", 64'(stray_cnt), 64'hFF);
    repeat (45) step();
    inj_en = 1'b0;
    step();
    @(negedge clk);
    chk("stray_cnt_sat", 64'(stray_cnt), 64'hFF);

    step();
    chk("issue_queue_empty", 64'(exp_issue.size()), 64'd0);
    chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
